// File: rtl/vram_arbiter_if.sv
// Requester-side and VRAM-pin-side signal bundle for vram_arbiter.
// Master is the requester/pin environment; slave is the arbiter.
interface vram_arbiter_if #(
  parameter int unsigned AW  = 13,
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 3
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    block;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    done;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic [AW-1:0]     ma_out;
  logic [DW-1:0]     md_out;
  logic [DW-1:0]     md_in;
  logic              md_oe;
  logic              ncs;
  logic              noe;
  logic              nwr;

  modport master (
    output req, we, addr, wdata, block, md_in,
    input  gnt, done, rdata, busy, ma_out, md_out, md_oe, ncs, noe, nwr
  );

  modport slave (
    input  req, we, addr, wdata, block, md_in,
    output gnt, done, rdata, busy, ma_out, md_out, md_oe, ncs, noe, nwr
  );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM access controller: arbitrates NCH requesters and sequences the
// chip-select, output-enable and write-strobe timing on the VRAM pins.
module vram_arbiter #(
  parameter int unsigned AW     = 13,
  parameter int unsigned DW     = 8,
  parameter int unsigned NCH    = 3,
  parameter int unsigned RR     = 0,
  parameter int unsigned RD_CYC = 2,
  parameter int unsigned WR_CYC = 2
) (
  input logic           clk,
  input logic           nreset,
  vram_arbiter_if.slave bus
);

  localparam int unsigned MAXC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int unsigned CNTW = $clog2(MAXC) + 1;
  localparam int unsigned IW   = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t         state;
  logic [CNTW-1:0] cnt;
  logic [IW-1:0]  kch;
  logic [IW-1:0]  last_grant;
  logic           wr_l;
  logic [NCH-1:0] gnt_q;
  logic [NCH-1:0] done_q;
  logic [DW-1:0]  rdata_q;
  logic           busy_q;
  logic [AW-1:0]  ma_q;
  logic [DW-1:0]  md_q;
  logic           md_oe_q;
  logic           ncs_q;
  logic           noe_q;
  logic           nwr_q;

  logic [NCH-1:0] elig;
  logic [IW-1:0]  win;
  logic [IW-1:0]  idx;
  logic           found;

  assign elig = bus.req & ~bus.block;

  // Winner search: from index 0 (fixed) or from last_grant+1 with wrap (round-robin)
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (RR != 0) ? IW'((32'(last_grant) + 32'd1 + i) % NCH) : IW'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cnt        <= '0;
      kch        <= '0;
      last_grant <= IW'(NCH - 1);
      wr_l       <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      ma_q       <= '0;
      md_q       <= '0;
      md_oe_q    <= 1'b0;
      ncs_q      <= 1'b1;
      noe_q      <= 1'b1;
      nwr_q      <= 1'b1;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state      <= SETUP;
            kch        <= win;
            last_grant <= win;
            wr_l       <= bus.we[win];
            ma_q       <= bus.addr[32'(win)*AW +: AW];
            md_q       <= bus.wdata[32'(win)*DW +: DW];
            gnt_q      <= NCH'(1) << win;
            busy_q     <= 1'b1;
            ncs_q      <= 1'b0;
            md_oe_q    <= bus.we[win];
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= wr_l ? CNTW'(WR_CYC) : CNTW'(RD_CYC);
          noe_q <= wr_l;
          nwr_q <= !wr_l;
        end
        ACCESS: begin
          if (cnt == CNTW'(1)) begin
            state  <= RECOVER;
            ncs_q  <= 1'b1;
            noe_q  <= 1'b1;
            nwr_q  <= 1'b1;
            done_q <= NCH'(1) << kch;
            if (!wr_l) rdata_q <= bus.md_in;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        RECOVER: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          md_oe_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.ma_out = ma_q;
  assign bus.md_out = md_q;
  assign bus.md_oe  = md_oe_q;
  assign bus.ncs    = ncs_q;
  assign bus.noe    = noe_q;
  assign bus.nwr    = nwr_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a fixed-priority default build and a round-robin
// RD_CYC=1/WR_CYC=4 build, both compared every cycle to a phase-based model.
module tb_vram_arbiter;
  localparam int unsigned AW  = 13;
  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 3;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req, we, block;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [DW-1:0]     md_in;
  bit                md_hold;

  int checks = 0;
  int errors = 0;

  vram_arbiter_if #(.AW(AW), .DW(DW), .NCH(NCH)) bus0 ();
  vram_arbiter_if #(.AW(AW), .DW(DW), .NCH(NCH)) bus1 ();

  vram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH), .RR(0), .RD_CYC(2), .WR_CYC(2))
    u_fp (.clk(clk), .nreset(nreset), .bus(bus0.slave));
  vram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH), .RR(1), .RD_CYC(1), .WR_CYC(4))
    u_rr (.clk(clk), .nreset(nreset), .bus(bus1.slave));

  assign bus0.req = req;   assign bus1.req = req;
  assign bus0.we = we;     assign bus1.we = we;
  assign bus0.addr = addr; assign bus1.addr = addr;
  assign bus0.wdata = wdata; assign bus1.wdata = wdata;
  assign bus0.block = block; assign bus1.block = block;
  assign bus0.md_in = md_in; assign bus1.md_in = md_in;

  logic [NCH-1:0] o_gnt [2];
  logic [NCH-1:0] o_done [2];
  logic [DW-1:0]  o_rdata [2];
  logic [DW-1:0]  o_md [2];
  logic [AW-1:0]  o_ma [2];
  logic           o_busy [2];
  logic           o_oe [2];
  logic           o_ncs [2];
  logic           o_noe [2];
  logic           o_nwr [2];

  assign o_gnt[0] = bus0.gnt;     assign o_gnt[1] = bus1.gnt;
  assign o_done[0] = bus0.done;   assign o_done[1] = bus1.done;
  assign o_rdata[0] = bus0.rdata; assign o_rdata[1] = bus1.rdata;
  assign o_md[0] = bus0.md_out;   assign o_md[1] = bus1.md_out;
  assign o_ma[0] = bus0.ma_out;   assign o_ma[1] = bus1.ma_out;
  assign o_busy[0] = bus0.busy;   assign o_busy[1] = bus1.busy;
  assign o_oe[0] = bus0.md_oe;    assign o_oe[1] = bus1.md_oe;
  assign o_ncs[0] = bus0.ncs;     assign o_ncs[1] = bus1.ncs;
  assign o_noe[0] = bus0.noe;     assign o_noe[1] = bus1.noe;
  assign o_nwr[0] = bus0.nwr;     assign o_nwr[1] = bus1.nwr;

  // Model: one transaction record per instance, outputs derived from the phase
  // (cycles elapsed since the grant edge).
  bit            mbusy [2];
  int unsigned   mph [2];
  int unsigned   mch [2];
  bit            mwe [2];
  int unsigned   mlast [2];
  logic [AW-1:0] mma [2];
  logic [DW-1:0] mmd [2];
  logic [DW-1:0] mrd [2];

  function automatic int unsigned rdc(int m);
    return (m == 0) ? 2 : 1;
  endfunction

  function automatic int unsigned wrc(int m);
    return (m == 0) ? 2 : 4;
  endfunction

  function automatic int unsigned pick(int m, logic [NCH-1:0] e);
    for (int unsigned i = 0; i < NCH; i++) begin
      int unsigned j;
      j = (m == 1) ? (mlast[m] + 1 + i) % NCH : i;
      if (e[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mbusy[m] = 1'b0; mph[m] = 0; mch[m] = 0; mwe[m] = 1'b0;
      mlast[m] = NCH - 1; mma[m] = '0; mmd[m] = '0; mrd[m] = '0;
    end
  endtask

  task automatic model_edge();
    logic [NCH-1:0] e;
    e = req & ~block;
    for (int m = 0; m < 2; m++) begin
      if (!mbusy[m]) begin
        if (e != '0) begin
          int unsigned k;
          k = pick(m, e);
          mbusy[m] = 1'b1; mph[m] = 0; mch[m] = k; mwe[m] = we[k]; mlast[m] = k;
          mma[m] = addr[k*AW +: AW];
          mmd[m] = wdata[k*DW +: DW];
        end
      end else begin
        int unsigned c;
        c = mwe[m] ? wrc(m) : rdc(m);
        mph[m] = mph[m] + 1;
        if (mph[m] == c + 1 && !mwe[m]) mrd[m] = md_in;
        if (mph[m] == c + 2) mbusy[m] = 1'b0;
      end
    end
  endtask

  task automatic chk(string tag, int m, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d t=%0t observed %0h expected %0h", tag, m, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int unsigned c;
      bit a, strobe;
      logic [NCH-1:0] oh;
      c = mwe[m] ? wrc(m) : rdc(m);
      a = mbusy[m];
      oh = NCH'(1) << mch[m];
      strobe = a && mph[m] >= 1 && mph[m] <= c;
      chk("busy", m, 32'(o_busy[m]), 32'(a));
      chk("gnt", m, 32'(o_gnt[m]), (a && mph[m] == 0) ? 32'(oh) : 32'd0);
      chk("done", m, 32'(o_done[m]), (a && mph[m] == c + 1) ? 32'(oh) : 32'd0);
      chk("ncs", m, 32'(o_ncs[m]), 32'(!(a && mph[m] <= c)));
      chk("noe", m, 32'(o_noe[m]), 32'(!(strobe && !mwe[m])));
      chk("nwr", m, 32'(o_nwr[m]), 32'(!(strobe && mwe[m])));
      chk("md_oe", m, 32'(o_oe[m]), 32'(a && mwe[m]));
      chk("ma_out", m, 32'(o_ma[m]), 32'(mma[m]));
      chk("md_out", m, 32'(o_md[m]), 32'(mmd[m]));
      chk("rdata", m, 32'(o_rdata[m]), 32'(mrd[m]));
    end
  endtask

  // One clock: model consumes the inputs the DUT will sample, then compare.
  task automatic step();
    if (!md_hold) md_in = DW'($urandom());
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    req = '0; we = '0; block = '0; addr = '0; wdata = '0; md_in = '0;
    md_hold = 1'b0;
    nreset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 nreset = 1'b1;

    // Single read on ch2
    md_hold = 1'b1; md_in = 8'h5A;
    req = 3'b100; we = 3'b000; addr[2*AW +: AW] = 13'h1ABC;
    step();
    chk("rd_gnt", 0, 32'(o_gnt[0]), 32'h4);
    chk("rd_ma", 0, 32'(o_ma[0]), 32'h1ABC);
    req = '0;
    repeat (3) step();
    chk("rd_done", 0, 32'(o_done[0]), 32'h4);
    chk("rd_rdata", 0, 32'(o_rdata[0]), 32'h5A);
    md_hold = 1'b0;
    repeat (3) step();

    // Single write on ch1
    req = 3'b010; we = 3'b010; addr[1*AW +: AW] = 13'h0010; wdata[1*DW +: DW] = 8'hC3;
    step();
    req = '0; we = '0; wdata = '0;
    chk("wr_md", 0, 32'(o_md[0]), 32'hC3);
    repeat (7) step();

    // All channels requesting continuously
    req = 3'b111;
    for (int i = 0; i < 30; i++) begin
      we = NCH'($urandom());
      addr = (NCH*AW)'({$urandom(), $urandom()});
      wdata = (NCH*DW)'($urandom());
      step();
    end
    req = '0;
    repeat (8) step();

    // Blocking: masked request, release, then block raised mid-access
    req = 3'b100; we = '0; block = 3'b100;
    repeat (4) step();
    chk("blk_busy", 0, 32'(o_busy[0]), 32'd0);
    block = '0;
    step();
    chk("blk_gnt", 0, 32'(o_gnt[0]), 32'h4);
    step();
    block = 3'b100; addr = (NCH*AW)'({$urandom(), $urandom()});
    repeat (6) step();
    block = '0; req = '0;
    repeat (4) step();

    // Reset pulse during a write access
    req = 3'b001; we = 3'b001; wdata[0 +: DW] = 8'h77;
    step();
    step();
    #2 nreset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 nreset = 1'b1;
    repeat (8) step();
    req = '0; we = '0;
    repeat (6) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req = NCH'($urandom());
      we = NCH'($urandom());
      block = ($urandom_range(0, 3) == 0) ? NCH'($urandom()) : '0;
      addr = (NCH*AW)'({$urandom(), $urandom()});
      wdata = (NCH*DW)'($urandom());
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
